// File: rtl/leaf_pkg.sv
// Definitions shared by the leaf shells and the user-side FIFO: the default
// word width and the vld/ack transfer rule.
package leaf_pkg;
  localparam int PAYLOAD_BITS_DEF = 32;

  // A word moves on any cycle where the producer's vld and the consumer's ack are both high.
  function automatic logic xfer(input logic vld, input logic ack);
    return vld & ack;
  endfunction
endpackage

// File: rtl/user_port_fifo_if.sv
// Stream bus between the leaf interface, the user FIFO and the kernel.
// The slave modport is the FIFO side.
interface user_port_fifo_if
  import leaf_pkg::*;
#(
  parameter int PAYLOAD_BITS = PAYLOAD_BITS_DEF,
  parameter int DEPTH_BITS   = 4
);
  logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user;
  logic                    vld_interface2user;
  logic                    ack_user2interface;
  logic [PAYLOAD_BITS-1:0] dout_fifo2kernel;
  logic                    vld_fifo2kernel;
  logic                    ack_kernel2fifo;
  logic [DEPTH_BITS:0]     count;
  logic                    almost_full;
  logic                    drop_err;

  modport slave (
    input  dout_leaf_interface2user, vld_interface2user, ack_kernel2fifo,
    output ack_user2interface, dout_fifo2kernel, vld_fifo2kernel,
           count, almost_full, drop_err
  );

  modport master (
    output dout_leaf_interface2user, vld_interface2user, ack_kernel2fifo,
    input  ack_user2interface, dout_fifo2kernel, vld_fifo2kernel,
           count, almost_full, drop_err
  );
endinterface

// File: rtl/user_port_fifo_ram.sv
// Simple dual-port storage: one synchronous write port and one asynchronous
// read port. The array has no reset, so it maps onto distributed RAM.
module user_port_fifo_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/user_port_fifo.sv
// First-word-fall-through FIFO between the leaf interface and the user kernel.
// The handshake outputs depend only on the registered count.
module user_port_fifo
  import leaf_pkg::*;
#(
  parameter int PAYLOAD_BITS = PAYLOAD_BITS_DEF,
  parameter int DEPTH_BITS   = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic             clk_user,
  input  logic             reset,
  user_port_fifo_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] CNT_FULL = DEPTH[DEPTH_BITS:0];
  localparam logic [DEPTH_BITS:0] CNT_AF   = AFULL_THRESH[DEPTH_BITS:0];

  logic [DEPTH_BITS-1:0]   wr_ptr, rd_ptr;
  logic [DEPTH_BITS:0]     count_q, count_nxt;
  logic                    af_q, drop_q;
  logic                    push, pop;
  logic [PAYLOAD_BITS-1:0] rd_data;

  assign bus.ack_user2interface = (count_q != CNT_FULL);
  assign bus.vld_fifo2kernel    = (count_q != '0);
  assign push = xfer(bus.vld_interface2user, bus.ack_user2interface);
  assign pop  = xfer(bus.vld_fifo2kernel, bus.ack_kernel2fifo);

  always_comb begin
    count_nxt = count_q;
    case ({push, pop})
      2'b10:   count_nxt = count_q + 1'b1;
      2'b01:   count_nxt = count_q - 1'b1;
      default: count_nxt = count_q;
    endcase
  end

  always_ff @(posedge clk_user) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      af_q    <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_nxt;
      // Computed from the next-state count so the flag lines up with count.
      af_q    <= (count_nxt >= CNT_AF);
      if (bus.vld_interface2user && (count_q == CNT_FULL)) drop_q <= 1'b1;
    end
  end

  user_port_fifo_ram #(
    .DATA_W (PAYLOAD_BITS),
    .ADDR_W (DEPTH_BITS)
  ) u_ram (
    .clk   (clk_user),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (bus.dout_leaf_interface2user),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // The storage array is never cleared, so the output is forced to zero while empty.
  assign bus.dout_fifo2kernel = bus.vld_fifo2kernel ? rd_data : '0;
  assign bus.count            = count_q;
  assign bus.almost_full      = af_q;
  assign bus.drop_err         = drop_q;
endmodule
